// File: rtl/axis_frame_source.sv
// axis_frame_source: holds one frame in on-chip RAM (loaded through a simple
// write port while idle) and replays it as AXI-Stream N times or continuously,
// marking frame start on tuser and line end on tlast, with full backpressure.
// Optional feature: define GAP_INSERT_EN to insert cfg_gap idle cycles after
// every beat; without it cfg_gap is ignored and beats are back-to-back.
module axis_frame_source #(
    parameter int DATA_W    = 8,
    parameter int MAX_W     = 128,
    parameter int MAX_H     = 128,
    parameter int FRM_CNT_W = 16,
    parameter int GAP_W     = 8,
    localparam int AW = $clog2(MAX_W * MAX_H),
    localparam int WW = $clog2(MAX_W + 1),
    localparam int HW = $clog2(MAX_H + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_en,
    input  logic [AW-1:0]        ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 ld_ready,
    input  logic [WW-1:0]        cfg_width,
    input  logic [HW-1:0]        cfg_height,
    input  logic [FRM_CNT_W-1:0] cfg_frames,
    input  logic [GAP_W-1:0]     cfg_gap,
    input  logic                 start,
    input  logic                 stop,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 busy,
    output logic                 done_pulse,
    output logic                 cfg_err,
    output logic [FRM_CNT_W-1:0] frames_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
`ifdef GAP_INSERT_EN
        S_GAP,
`endif
        S_DONE
    } state_t;

    // One pipeline entry: pixel plus its line/frame markers and end-of-frame tag.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              user;
        logic              eof;
    } beat_t;

    localparam logic [WW-1:0] MAX_W_L = WW'(MAX_W);
    localparam logic [HW-1:0] MAX_H_L = HW'(MAX_H);

    state_t               state;
    logic [DATA_W-1:0]    mem [MAX_W*MAX_H];
    logic [DATA_W-1:0]    ram_q;
    logic [AW-1:0]        rd_addr;
    logic [WW-1:0]        col, width_q;
    logic [HW-1:0]        row, height_q;
    logic [FRM_CNT_W-1:0] frames_q, frames_inc;
    logic                 stop_seen;
    logic                 rd_vld, rd_last, rd_user, rd_eof;
    beat_t                head, skid, head_n, skid_n, rd_beat;
    logic                 head_vld, skid_vld, head_vld_n, skid_vld_n;
    logic                 tvalid_q;
    logic                 active, pop, fin, last_run, issue, size_bad;
    logic [1:0]           occ;

`ifdef GAP_INSERT_EN
    logic [GAP_W-1:0]     gap_q, gap_cnt;
`else
    logic                 unused_cfg_gap;
    assign unused_cfg_gap = ^cfg_gap;
`endif

    assign m_axis_tdata  = head.data;
    assign m_axis_tlast  = head.last;
    assign m_axis_tuser  = head.user;
    assign m_axis_tvalid = tvalid_q;

    // Frame store: loaded only while idle, one synchronous read per prefetch.
    // NOTE: the pixel array is deliberately left out of reset; only control state needs a known value.
    always_ff @(posedge clk) begin
        if (ld_en && state == S_IDLE) mem[ld_addr] <= ld_data;
        if (issue) ram_q <= mem[rd_addr];
    end

    // Handshake, frame-end decision, prefetch credit and output/skid buffer next state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        active     = (state != S_IDLE) && (state != S_DONE);
        pop        = tvalid_q && m_axis_tready;
        fin        = pop && head.eof;
        frames_inc = frames_sent + FRM_CNT_W'(1);
        last_run   = fin && (((frames_q != '0) && (frames_inc == frames_q)) || stop_seen || stop);
        size_bad   = (cfg_width == '0) || (cfg_height == '0) ||
                     (cfg_width > MAX_W_L) || (cfg_height > MAX_H_L);
        rd_beat    = '{data: ram_q, last: rd_last, user: rd_user, eof: rd_eof};
        // Entries held after this edge; a read may issue only if its data will have a slot.
        occ        = 2'(head_vld) + 2'(skid_vld) + 2'(rd_vld) - 2'(pop);
        issue      = active && (occ < 2'd2);
        head_n     = head;
        head_vld_n = head_vld;
        skid_n     = skid;
        skid_vld_n = skid_vld;
        if (pop) begin
            if (skid_vld) begin
                head_n     = skid;
                head_vld_n = 1'b1;
                skid_n     = rd_beat;
                skid_vld_n = rd_vld;
            end else begin
                head_n     = rd_beat;
                head_vld_n = rd_vld;
                skid_vld_n = 1'b0;
            end
        end else if (rd_vld) begin
            if (!head_vld) begin
                head_n     = rd_beat;
                head_vld_n = 1'b1;
            end else begin
                skid_n     = rd_beat;
                skid_vld_n = 1'b1;
            end
        end
    end

    // Control FSM with registered status outputs, address generator and stream pipeline.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= S_IDLE;
            ld_ready    <= 1'b1;
            busy        <= 1'b0;
            done_pulse  <= 1'b0;
            cfg_err     <= 1'b0;
            frames_sent <= '0;
            tvalid_q    <= 1'b0;
            head        <= '0;
            head_vld    <= 1'b0;
            skid        <= '0;
            skid_vld    <= 1'b0;
            rd_vld      <= 1'b0;
            rd_last     <= 1'b0;
            rd_user     <= 1'b0;
            rd_eof      <= 1'b0;
            rd_addr     <= '0;
            col         <= '0;
            row         <= '0;
            width_q     <= '0;
            height_q    <= '0;
            frames_q    <= '0;
            stop_seen   <= 1'b0;
`ifdef GAP_INSERT_EN
            gap_q       <= '0;
            gap_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        width_q     <= cfg_width;
                        height_q    <= cfg_height;
                        frames_q    <= cfg_frames;
`ifdef GAP_INSERT_EN
                        gap_q       <= cfg_gap;
`endif
                        frames_sent <= '0;
                        rd_addr     <= '0;
                        col         <= '0;
                        row         <= '0;
                        stop_seen   <= 1'b0;
                        busy        <= 1'b1;
                        ld_ready    <= 1'b0;
                        cfg_err     <= size_bad;
                        if (size_bad) begin
                            done_pulse <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            state      <= S_PRIME;
                        end
                    end
                end
                S_DONE: begin
                    done_pulse <= 1'b0;
                    busy       <= 1'b0;
                    ld_ready   <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    head     <= head_n;
                    head_vld <= head_vld_n;
                    skid     <= skid_n;
                    skid_vld <= skid_vld_n;
                    rd_vld   <= issue;
                    if (issue) begin
                        rd_last <= (col == width_q - 1'b1);
                        rd_user <= (col == '0) && (row == '0);
                        rd_eof  <= (col == width_q - 1'b1) && (row == height_q - 1'b1);
                        if (col == width_q - 1'b1) begin
                            col <= '0;
                            if (row == height_q - 1'b1) begin
                                row     <= '0;
                                rd_addr <= '0;
                            end else begin
                                row     <= row + 1'b1;
                                rd_addr <= rd_addr + 1'b1;
                            end
                        end else begin
                            col     <= col + 1'b1;
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                    if (fin) frames_sent <= frames_inc;
                    if (last_run) begin
                        // Run over: discard prefetched beats and report completion.
                        head_vld   <= 1'b0;
                        skid_vld   <= 1'b0;
                        rd_vld     <= 1'b0;
                        tvalid_q   <= 1'b0;
                        done_pulse <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        stop_seen <= fin ? 1'b0 : (stop_seen || stop);
`ifdef GAP_INSERT_EN
                        if (state == S_GAP) begin
                            if (gap_cnt == '0) begin
                                state    <= S_STREAM;
                                tvalid_q <= head_vld_n;
                            end else begin
                                gap_cnt  <= gap_cnt - 1'b1;
                                tvalid_q <= 1'b0;
                            end
                        end else if (pop && gap_q != '0) begin
                            state    <= S_GAP;
                            gap_cnt  <= gap_q - 1'b1;
                            tvalid_q <= 1'b0;
                        end else begin
                            state    <= S_STREAM;
                            tvalid_q <= head_vld_n;
                        end
`else
                        state    <= S_STREAM;
                        tvalid_q <= head_vld_n;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_source.sv
// tb_axis_frame_source: scoreboard bench for axis_frame_source. Each run's
// expected beats are computed from the loaded pixel image and the frame size,
// pushed into a queue at start, and popped by an independent monitor on every
// handshake. Compile with GAP_INSERT_EN defined to also exercise beat gaps.
module tb_axis_frame_source;

    logic        clk, rst_n;
    logic        ld_en, ld_ready;
    logic [13:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  cfg_width, cfg_height, cfg_gap;
    logic [15:0] cfg_frames;
    logic        start, stop;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic        busy, done_pulse, cfg_err;
    logic [15:0] frames_sent;

    axis_frame_source dut (
        .clk(clk), .rst_n(rst_n),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_frames(cfg_frames), .cfg_gap(cfg_gap),
        .start(start), .stop(stop),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .busy(busy), .done_pulse(done_pulse), .cfg_err(cfg_err), .frames_sent(frames_sent)
    );

    typedef struct { logic [7:0] data; logic last; logic user; } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [16384];
    int         errors = 0, checks = 0;
    int         beats = 0, done_cnt = 0, ncyc = 0;
    int         first_hs = 0, last_hs = 0;
    bit         mark_first = 0;
    int         rdy_mode = 2;   // 0: always ready, 1: random, 2: held low

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Sink ready generator, updated just after each rising edge.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every handshake against the scoreboard, checks stall stability and done pulses.
    initial begin
        bit         stalled = 0;
        logic       prev_done = 0;
        logic [9:0] held = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                stalled   = 0;
                prev_done = 0;
            end else begin
                if (done_pulse) begin
                    done_cnt++;
                    check("done_single_cycle", prev_done, 0);
                    check("done_tvalid_low", m_axis_tvalid, 0);
                end
                prev_done = done_pulse;
                if (stalled) begin
                    check("stall_tvalid_held", m_axis_tvalid, 1);
                    check("stall_beat_stable", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, held);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (mark_first) begin
                        first_hs   = ncyc;
                        mark_first = 0;
                    end
                    last_hs = ncyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat %0d: got data %0h, required no beat", beats, m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat%0d_data", beats), m_axis_tdata, e.data);
                        check($sformatf("beat%0d_tlast", beats), m_axis_tlast, e.last);
                        check($sformatf("beat%0d_tuser", beats), m_axis_tuser, e.user);
                    end
                    beats++;
                end
                stalled = m_axis_tvalid && !m_axis_tready;
                held    = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
            end
        end
    end

    // Reference model: n frames of the stored image, raster order, markers from position.
    task automatic push_frames(input int w, input int h, input int n);
        exp_t e;
        for (int f = 0; f < n; f++) begin
            for (int p = 0; p < w * h; p++) begin
                e.data = mem_m[p];
                e.last = ((p % w) == w - 1);
                e.user = (p == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic load_frame(input int n, input bit ramp);
        for (int a = 0; a < n; a++) begin
            @(posedge clk);
            #1;
            ld_en   = 1'b1;
            ld_addr = 14'(a);
            ld_data = ramp ? 8'(a) : 8'($urandom);
            mem_m[a] = ld_data;
        end
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    // Returns #1 after the edge that samples start.
    task automatic run_start(input int w, input int h, input int n, input int gap);
        @(posedge clk);
        #1;
        cfg_width  = 8'(w);
        cfg_height = 8'(h);
        cfg_frames = 16'(n);
        cfg_gap    = 8'(gap);
        start      = 1'b1;
        mark_first = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int prev, input int budget);
        for (int i = 0; i < budget && done_cnt == prev; i++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_done_count"}, done_cnt - prev, 1);
        @(posedge clk);
        #1;
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_ld_ready"}, ld_ready, 1);
        check({name, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int base, input int target, input int budget);
        for (int i = 0; i < budget && beats - base < target; i++) begin
            @(posedge clk);
            #1;
        end
        check("wait_beats_reached", beats - base >= target, 1);
    endtask

    initial begin
        int base, dprev, w, h, n;
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        cfg_width = '0; cfg_height = '0; cfg_frames = '0; cfg_gap = '0;
        start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done_pulse, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_frames_sent", frames_sent, 0);
        check("rst_tdata", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, 0);
        rst_n = 1'b1;
        rdy_mode = 0;

        // 4x3 ramp, one frame, always ready: latency, back-to-back beats.
        load_frame(12, 1);
        push_frames(4, 3, 1);
        dprev = done_cnt; base = beats;
        run_start(4, 3, 1, 0);
        check("lat_start_edge_tvalid", m_axis_tvalid, 0);
        check("lat_start_edge_busy", busy, 1);
        @(posedge clk); #1;
        check("lat_1clk_tvalid", m_axis_tvalid, 0);
        @(posedge clk); #1;
        check("lat_2clk_tvalid", m_axis_tvalid, 1);
        wait_done("ramp", dprev, 200);
        check("ramp_frames_sent", frames_sent, 1);
        check("ramp_beat_count", beats - base, 12);
        check("ramp_back_to_back_span", last_hs - first_hs, 11);

        // Same frame under random backpressure.
        rdy_mode = 1;
        push_frames(4, 3, 1);
        dprev = done_cnt; base = beats;
        run_start(4, 3, 1, 0);
        wait_done("stall", dprev, 400);
        check("stall_beat_count", beats - base, 12);
        rdy_mode = 0;

        // Continuous run stopped during pixel 5 of frame 2; stray load and start must be ignored.
        push_frames(4, 3, 3);
        dprev = done_cnt; base = beats;
        run_start(4, 3, 0, 0);
        wait_beats(base, 29, 200);
        stop = 1'b1; start = 1'b1; cfg_width = 8'd2;
        ld_en = 1'b1; ld_addr = 14'd11; ld_data = ~mem_m[11];
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0; ld_en = 1'b0; cfg_width = 8'd4;
        wait_done("cont", dprev, 200);
        check("cont_frames_sent", frames_sent, 3);
        check("cont_beat_count", beats - base, 36);

        // Reset in the middle of a frame, then restart from pixel 0.
        push_frames(4, 3, 1);
        dprev = done_cnt; base = beats;
        run_start(4, 3, 1, 0);
        wait_beats(base, 7, 100);
        rst_n = 1'b0; rdy_mode = 2;
        @(posedge clk); #1;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ld_ready", ld_ready, 1);
        check("midrst_done", done_pulse, 0);
        exp_q.delete();
        rst_n = 1'b1; rdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - dprev, 0);
        push_frames(4, 3, 1);
        dprev = done_cnt; base = beats;
        run_start(4, 3, 1, 0);
        wait_done("restart", dprev, 200);
        check("restart_beat_count", beats - base, 12);

        // Illegal size: no beats, sticky error, immediate done.
        dprev = done_cnt; base = beats;
        run_start(0, 3, 1, 0);
        check("err_cfg_err", cfg_err, 1);
        check("err_done_pulse", done_pulse, 1);
        check("err_tvalid", m_axis_tvalid, 0);
        @(posedge clk); #1;
        check("err_done_count", done_cnt - dprev, 1);
        check("err_busy", busy, 0);
        check("err_no_beats", beats - base, 0);

        // Full 128x128 frame clears the error.
        load_frame(16384, 0);
        push_frames(128, 128, 1);
        dprev = done_cnt; base = beats;
        run_start(128, 128, 1, 0);
        check("max_cfg_err_cleared", cfg_err, 0);
        wait_done("max", dprev, 20000);
        check("max_beat_count", beats - base, 16384);
        check("max_frames_sent", frames_sent, 1);

        // 1x1 image, three frames: every beat is line end and frame start.
        load_frame(1, 0);
        push_frames(1, 1, 3);
        dprev = done_cnt;
        run_start(1, 1, 3, 0);
        wait_done("one_px", dprev, 100);
        check("one_px_frames_sent", frames_sent, 3);

        // Random sizes, frame counts, gaps and backpressure.
        rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 5);
            n = $urandom_range(1, 3);
            load_frame(w * h, 0);
            push_frames(w, h, n);
            dprev = done_cnt;
            run_start(w, h, n, $urandom_range(0, 2));
            wait_done($sformatf("rand%0d", r), dprev, w * h * n * 20 + 200);
            check($sformatf("rand%0d_frames_sent", r), frames_sent, 32'(n));
        end
        rdy_mode = 0;

`ifdef GAP_INSERT_EN
        // Two idle cycles after each beat except the last one.
        load_frame(12, 1);
        push_frames(4, 3, 1);
        dprev = done_cnt; base = beats;
        run_start(4, 3, 1, 2);
        wait_done("gap", dprev, 200);
        check("gap_beat_count", beats - base, 12);
        check("gap_span", last_hs - first_hs, 33);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- Synthesisable, parametrised replacement for the behavioural pixel-feed loop driving the MRELBP top's AXI-Stream input.
- Holds one frame in internal RAM, loaded through a simple write port.
- Replays the frame N times, or continuously, as AXI-Stream with frame (tuser) and line (tlast) markers, obeying full tready backpressure.
- Sits between the capture/DMA path or test harness and top's s_axis port. Pulses done_pulse at end of run, suitable for irq aggregation.

Parameters:
- DATA_W, 8, pixel/beat width in bits.
- MAX_W, 128, maximum image width in pixels.
- MAX_H, 128, maximum image height in lines.
- FRM_CNT_W, 16, width of frame counters.
- GAP_W, 8, width of the inter-beat gap field (used only with GAP_INSERT_EN).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ld_en  in  1  RAM write strobe.
- ld_addr  in  clog2(MAX_W*MAX_H)  linear pixel address (row*cfg_width+col).
- ld_data  in  DATA_W  pixel to store.
- ld_ready  out  1  high when writes are accepted (IDLE only).
- cfg_width  in  clog2(MAX_W+1)  active width; sampled on accepted start.
- cfg_height  in  clog2(MAX_H+1)  active height; sampled on accepted start.
- cfg_frames  in  FRM_CNT_W  frames to send; 0 = continuous until stop.
- cfg_gap  in  GAP_W  idle cycles after each beat (GAP_INSERT_EN only).
- start  in  1  one-cycle start request.
- stop  in  1  request to finish after the current frame.
- m_axis_tdata  out  DATA_W  pixel.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last pixel of a line.
- m_axis_tuser  out  1  first pixel of a frame.
- busy  out  1  high outside IDLE.
- done_pulse  out  1  one-cycle pulse at end of run.
- cfg_err  out  1  sticky flag: start issued with an illegal size.
- frames_sent  out  FRM_CNT_W  completed frames in the current/last run (wraps).

Behaviour:
- Reset (rst_n=0 at a clk edge): every output 0 except ld_ready=1; FSM to IDLE; counters cleared. RAM contents are not reset.
- Reset mid-stream: tvalid drops at that edge, no further beats, and no done_pulse is issued.
- FSM states: IDLE, PRIME, STREAM, GAP (macro only), DONE.
- IDLE:
  - ld_ready=1 and writes land at ld_addr; ld_en is ignored in all other states.
  - start latches the cfg_* inputs and clears frames_sent and cfg_err.
  - Illegal size (width=0, height=0, width>MAX_W or height>MAX_H): set cfg_err, go to DONE, emit no beats.
  - Legal size: go to PRIME.
- PRIME: issue RAM read of address 0 (synchronous RAM, 1-cycle read). First tvalid asserts 2 cycles after the start edge.
- STREAM: output register plus a one-entry prefetch/skid buffer.
  - tdata, tlast and tuser stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - Sustained throughput is 1 beat/clk when tready=1.
- Markers:
  - col counts 0..width-1 and row counts 0..height-1.
  - tlast=1 when col==width-1.
  - tuser=1 when col==0 and row==0, on every frame.
  - Address wraps to 0 after the last pixel of a frame.
- Frame completion, on the handshake of pixel (width-1, height-1):
  - frames_sent increments, wrapping at 2^FRM_CNT_W.
  - Go to DONE if frames_sent+1==cfg_frames (cfg_frames!=0), or if stop was seen at any cycle during this frame (latched).
  - Otherwise continue to frame 0 pixel 0 with no bubble.
- stop in IDLE or DONE is ignored.
- start while busy is ignored; the cfg_* inputs are not re-sampled.
- DONE: done_pulse=1 for exactly one cycle with tvalid=0, then IDLE.
- 1x1 image: every beat has tlast=1 and tuser=1.

Optional Feature:
- Macro GAP_INSERT_EN.
- Defined: after each handshake, enter GAP for cfg_gap cycles with tvalid=0, then resume STREAM. cfg_gap=0 behaves as back-to-back. GAP is skipped after the final beat of a run.
- Undefined: the GAP state and the cfg_gap logic are absent, the cfg_gap port still exists but is ignored, and beats are always back-to-back.

Test Plan:
- Load a 4x3 ramp (0..11); width=4, height=3, frames=1; start, tready=1 → beats 0..11 on consecutive cycles; tlast on 3, 7, 11; tuser on 0 only; first tvalid 2 clk after start; done_pulse once; frames_sent=1.
- Same frame, tready toggled pseudo-randomly → identical sequence with no drops or duplicates; tdata/tlast/tuser stable while stalled.
- frames=0 (continuous), assert stop during pixel 5 of frame 2 → exactly 3 complete frames (36 beats), tuser on beats 0, 12, 24, then done_pulse; frames_sent=3.
- start with width=0 → no tvalid, cfg_err=1, done_pulse 1 cycle later. Then start with 128x128 (16384 beats) → cfg_err cleared, final tlast on beat 16383.
- rst_n=0 at beat 7 of a frame → tvalid=0 at that edge, busy=0, no done_pulse. Restart sends from pixel 0 with tuser=1.
- GAP_INSERT_EN defined, cfg_gap=2, 4x3 frame → tvalid pattern 1,0,0 repeated; 12 beats in 34 cycles; no gap after beat 11.
